// File: rtl/sram_march_bist_if.sv
// sram_march_bist_if: BIST control/status and SRAM port bundle.
// master = BIST engine side, slave = SRAM/host side.
interface sram_march_bist_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              BIST_start;
    logic [1:0]        BIST_mode;
    logic [ADDR_W-1:0] BIST_address;
    logic [DATA_W-1:0] BIST_write_data;
    logic              BIST_we_n;
    logic [DATA_W-1:0] BIST_read_data;
    logic              BIST_finish;
    logic              BIST_mismatch;
    logic [ADDR_W-1:0] BIST_fail_address;
    logic [15:0]       BIST_fail_count;
    modport master (
        input  BIST_start, BIST_mode, BIST_read_data,
        output BIST_address, BIST_write_data, BIST_we_n, BIST_finish,
               BIST_mismatch, BIST_fail_address, BIST_fail_count
    );
    modport slave (
        output BIST_start, BIST_mode, BIST_read_data,
        input  BIST_address, BIST_write_data, BIST_we_n, BIST_finish,
               BIST_mismatch, BIST_fail_address, BIST_fail_count
    );
endinterface

// File: rtl/sram_march_bist.sv
// sram_march_bist: march-style SRAM BIST (write/read up, write-inverse/read down).
// Define SRAM_BIST_ERR_LOG_EN to enable fail_address/fail_count logging.
module sram_march_bist #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    sram_march_bist_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE_UP, S_READ_UP, S_DRAIN_UP, S_WRITE_DOWN, S_READ_DOWN, S_DRAIN_DOWN
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          we_n_q, we_n_d;
    logic                          finish_q, finish_d;
    logic                          mismatch_q, mismatch_d;
    logic                          start_q;
    logic [1:0]                    mode_q, mode_d;
    logic [2:0]                    drain_q, drain_d;
    logic [RD_LAT-1:0]             pv_q, pv_d;
    logic [RD_LAT-1:0][ADDR_W-1:0] pa_q, pa_d;
    logic [RD_LAT-1:0][DATA_W-1:0] pe_q, pe_d;
    logic                          start, issue, down, mism;
    logic [DATA_W-1:0]             word;

    function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] cb;
        for (int i = 0; i < DATA_W; i++) cb[i] = a[0] ^ ~i[0];
        return m == 2'd1 ? cb : m == 2'd2 ? '0 : DATA_W'(a);
    endfunction

    assign start = bus.BIST_start && !start_q && state_q == S_IDLE;
    assign issue = state_q == S_READ_UP || state_q == S_READ_DOWN;
    assign down  = state_q == S_WRITE_DOWN || state_q == S_READ_DOWN || state_q == S_DRAIN_DOWN;
    // The same word is written and, on read passes, carried forward as the expectation.
    assign word  = down ? ~pat(mode_q, addr_q) : pat(mode_q, addr_q);
    assign mism  = pv_q[RD_LAT-1] && bus.BIST_read_data != pe_q[RD_LAT-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_n_d  = we_n_q;
        drain_d = '0;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                we_n_d = !start;
                if (start) state_d = S_WRITE_UP;
            end
            S_WRITE_UP: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == '1) begin
                    state_d = S_READ_UP;
                    we_n_d  = 1'b1;
                end
            end
            S_READ_UP: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == '1) state_d = S_DRAIN_UP;
            end
            S_DRAIN_UP: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(RD_LAT - 1)) begin
                    state_d = S_WRITE_DOWN;
                    addr_d  = '1;
                    we_n_d  = 1'b0;
                end
            end
            S_WRITE_DOWN: begin
                addr_d = addr_q - 1'b1;
                if (addr_q == '0) begin
                    state_d = S_READ_DOWN;
                    we_n_d  = 1'b1;
                end
            end
            S_READ_DOWN: begin
                addr_d = addr_q - 1'b1;
                if (addr_q == '0) begin
                    state_d = S_DRAIN_DOWN;
                    addr_d  = '0;
                end
            end
            default: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(RD_LAT - 1)) state_d = S_IDLE;
            end
        endcase
        finish_d   = state_d == S_IDLE;
        mismatch_d = start ? 1'b0 : mismatch_q | mism;
        mode_d     = start ? (bus.BIST_mode == 2'd3 ? 2'd0 : bus.BIST_mode) : mode_q;
    end

    always_comb begin
        pv_d[0] = issue;
        pa_d[0] = addr_q;
        pe_d[0] = word;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            we_n_q     <= 1'b1;
            finish_q   <= 1'b0;
            mismatch_q <= 1'b0;
            start_q    <= 1'b0;
            mode_q     <= 2'd0;
            drain_q    <= '0;
            pv_q       <= '0;
            pa_q       <= '0;
            pe_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_n_q     <= we_n_d;
            finish_q   <= finish_d;
            mismatch_q <= mismatch_d;
            start_q    <= bus.BIST_start;
            mode_q     <= mode_d;
            drain_q    <= drain_d;
            pv_q       <= pv_d;
            pa_q       <= pa_d;
            pe_q       <= pe_d;
        end
    end

    assign bus.BIST_address    = addr_q;
    assign bus.BIST_write_data = word;
    assign bus.BIST_we_n       = we_n_q;
    assign bus.BIST_finish     = finish_q;
    assign bus.BIST_mismatch   = mismatch_q;

`ifdef SRAM_BIST_ERR_LOG_EN
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [15:0]       fail_cnt_q, fail_cnt_d;

    always_comb begin
        fail_addr_d = start ? '0 : (mism && !mismatch_q) ? pa_q[RD_LAT-1] : fail_addr_q;
        fail_cnt_d  = start ? '0 : (mism && fail_cnt_q != 16'hFFFF) ? fail_cnt_q + 16'd1 : fail_cnt_q;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            fail_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            fail_addr_q <= fail_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    assign bus.BIST_fail_address = fail_addr_q;
    assign bus.BIST_fail_count   = fail_cnt_q;
`else
    logic unused_pa;
    assign unused_pa             = ^pa_q;
    assign bus.BIST_fail_address = '0;
    assign bus.BIST_fail_count   = '0;
`endif
endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: two BIST instances (RD_LAT 2 and 3) on behavioural SRAMs with
// injectable stuck-bit and forced-zero read faults; results checked via a scoreboard.
module tb_sram_march_bist;
    localparam int A = 4;
    localparam int D = 16;
`ifdef SRAM_BIST_ERR_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         start[2], stuck[2], force0[2];
    logic [1:0]   mode[2];
    logic         fin[2], mis[2], wen[2];
    logic [A-1:0] addr[2], fa[2];
    logic [D-1:0] wd[2];
    logic [15:0]  fc[2];
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic        mis;
        logic [A-1:0] fa;
        logic [15:0] fc;
    } exp_t;
    exp_t sb[$];

    genvar g;
    for (g = 0; g < 2; g++) begin : u
        localparam int L = (g == 0) ? 2 : 3;
        sram_march_bist_if #(.ADDR_W(A), .DATA_W(D)) bus ();
        sram_march_bist #(.ADDR_W(A), .DATA_W(D), .RD_LAT(L)) dut (
            .Clock (clk),
            .Resetn(rst_n),
            .bus   (bus)
        );
        logic [D-1:0]        mem[16];
        logic [L-1:0][D-1:0] rp;
        always @(posedge clk) begin
            if (!bus.BIST_we_n)
                mem[bus.BIST_address] <= bus.BIST_write_data |
                    ((stuck[g] && bus.BIST_address == 4'd5) ? 16'h0008 : 16'h0000);
            rp <= {rp[L-2:0], mem[bus.BIST_address]};
        end
        assign bus.BIST_start     = start[g];
        assign bus.BIST_mode      = mode[g];
        assign bus.BIST_read_data = force0[g] ? '0 : rp[L-1];
        assign fin[g]  = bus.BIST_finish;
        assign mis[g]  = bus.BIST_mismatch;
        assign wen[g]  = bus.BIST_we_n;
        assign addr[g] = bus.BIST_address;
        assign wd[g]   = bus.BIST_write_data;
        assign fa[g]   = bus.BIST_fail_address;
        assign fc[g]   = bus.BIST_fail_count;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int k, input logic [1:0] md);
        @(negedge clk);
        mode[k]  = md;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int n0, input int pulse_at, output int n);
        n = n0;
        while (fin[k] !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            start[k] = (n == pulse_at);
        end
    endtask

    task automatic run_check(input int k, input int n);
        exp_t e;
        e = sb.pop_front();
        chk("cycles", n, e.cyc);
        chk("mismatch", {31'd0, mis[k]}, {31'd0, e.mis});
        chk("fail_address", {28'd0, fa[k]}, {28'd0, e.fa});
        chk("fail_count", {16'd0, fc[k]}, {16'd0, e.fc});
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; stuck[i] = 1'b0; force0[i] = 1'b0; mode[i] = 2'd0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_finish", {31'd0, fin[i]}, 32'd0);
            chk("rst_we_n", {31'd0, wen[i]}, 32'd1);
            chk("rst_address", {28'd0, addr[i]}, 32'd0);
            chk("rst_mismatch", {31'd0, mis[i]}, 32'd0);
            chk("rst_fail_count", {16'd0, fc[i]}, 32'd0);
            chk("rst_fail_address", {28'd0, fa[i]}, 32'd0);
            chk("idle_write_data", {16'd0, wd[i]}, 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        #1 chk("finish_before_edge", {31'd0, fin[0]}, 32'd0);
        @(posedge clk);
        #1;
        chk("finish_after_release0", {31'd0, fin[0]}, 32'd1);
        chk("finish_after_release1", {31'd0, fin[1]}, 32'd1);

        sb.push_back('{68, 1'b0, 4'd0, 16'd0});
        start_run(0, 2'd0);
        chk("running_finish_low", {31'd0, fin[0]}, 32'd0);
        wait_done(0, 0, -1, n);
        run_check(0, n);

        stuck[0] = 1'b1;
        sb.push_back('{68, 1'b1, LOG ? 4'd5 : 4'd0, LOG ? 16'd1 : 16'd0});
        start_run(0, 2'd0);
        wait_done(0, 0, -1, n);
        run_check(0, n);
        stuck[0] = 1'b0;

        sb.push_back('{70, 1'b0, 4'd0, 16'd0});
        start_run(1, 2'd1);
        chk("cb_addr0", {28'd0, addr[1]}, 32'd0);
        chk("cb_we_n0", {31'd0, wen[1]}, 32'd0);
        chk("cb_data0", {16'd0, wd[1]}, 32'h5555);
        @(posedge clk);
        #1;
        chk("cb_addr1", {28'd0, addr[1]}, 32'd1);
        chk("cb_data1", {16'd0, wd[1]}, 32'hAAAA);
        wait_done(1, 1, -1, n);
        run_check(1, n);

        sb.push_back('{68, 1'b0, 4'd0, 16'd0});
        start_run(0, 2'd0);
        wait_done(0, 0, 10, n);
        run_check(0, n);

        sb.push_back('{68, 1'b0, 4'd0, 16'd0});
        start_run(0, 2'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("mode3_addr", {28'd0, addr[0]}, 32'd3);
        chk("mode3_data", {16'd0, wd[0]}, 32'd3);
        wait_done(0, 3, -1, n);
        run_check(0, n);

        force0[0] = 1'b1;
        sb.push_back('{68, 1'b1, LOG ? 4'd15 : 4'd0, LOG ? 16'd16 : 16'd0});
        start_run(0, 2'd2);
        wait_done(0, 0, -1, n);
        run_check(0, n);
        force0[0] = 1'b0;

        start_run(0, 2'd0);
        repeat (29) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_finish", {31'd0, fin[0]}, 32'd0);
        chk("midrst_we_n", {31'd0, wen[0]}, 32'd1);
        chk("midrst_address", {28'd0, addr[0]}, 32'd0);
        chk("midrst_mismatch", {31'd0, mis[0]}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("midrst_finish_held", {31'd0, fin[0]}, 32'd0);
        @(posedge clk);
        #1 chk("midrst_finish_up", {31'd0, fin[0]}, 32'd1);

        sb.push_back('{68, 1'b0, 4'd0, 16'd0});
        start_run(0, 2'd0);
        wait_done(0, 0, -1, n);
        run_check(0, n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
